dmac_arbiter: RTL and testbench
===============================

DMAC_ARBITER -- requirements
Module: dmac_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of peripheral request lines; legal range 2..8.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 dma_req  input  N_REQ  level request per peripheral, held until acknowledged.
REQ-005 req_mask  input  N_REQ  1 = requester enabled for arbitration.
REQ-006 hi_prio  input  N_REQ  1 = requester in high-priority class.
REQ-007 ch_irq  input  1  transfer-complete pulse from channel controller.
REQ-008 ch_err  input  1  bus error pulse from channel (nonzero HRESP seen).
REQ-009 err_clr  input  N_REQ  per-requester clear of sticky error flag.
REQ-010 channel_en  output  1  enable to channel controller.
REQ-011 cfg_load  output  1  one-cycle strobe to load source/destination/size registers for grant_id.
REQ-012 grant  output  N_REQ  one-hot current owner, all-zero when none.
REQ-013 grant_id  output  clog2(N_REQ)  binary index of current owner.
REQ-014 dma_ack  output  N_REQ  one-cycle completion pulse to owning requester.
REQ-015 err_flag  output  N_REQ  sticky per-requester error status.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN, ACK; all outputs registered or decoded from registered state only.
REQ-018 Eligible set SHALL be dma_req & req_mask & ~err_flag & ~suppress.
REQ-019 IDLE: if eligible set nonzero, select winner, register grant/grant_id, go LOAD; else stay IDLE with grant = 0.
REQ-020 Selection: if any eligible requester has hi_prio=1 choose only among those, else among all eligible; within the chosen class round-robin, first eligible index after last_id modulo N_REQ.
REQ-021 LOAD: cfg_load=1 for exactly one cycle, channel_en=0, go RUN.
REQ-022 RUN: channel_en=1; stay until ch_irq or ch_err; dma_req/req_mask/hi_prio changes ignored.
REQ-023 RUN with ch_err=1 (regardless of ch_irq): set err_flag[grant_id], channel_en=0 next cycle, go IDLE, no dma_ack.
REQ-024 RUN with ch_irq=1 and ch_err=0: go ACK.
REQ-025 ACK: dma_ack[grant_id]=1 for one cycle, channel_en=0, last_id <= grant_id, go IDLE.
REQ-026 suppress SHALL mask the just-acknowledged requester for the single IDLE cycle following ACK only.
REQ-027 last_id SHALL update only in ACK; error terminations leave it unchanged.
REQ-028 err_flag bit cleared by err_clr in the next cycle; simultaneous set and clear of same bit: set wins.
REQ-029 Latency: eligible request sampled in IDLE at edge t -> cfg_load high after t, channel_en high after t+1.
REQ-030 grant and grant_id SHALL stay stable from LOAD through ACK inclusive and clear on entry to IDLE.
REQ-031 At most one dma_ack bit and at most one grant bit SHALL be high in any cycle.

Reset
REQ-032 rst low SHALL asynchronously force state IDLE, channel_en=0, cfg_load=0, grant=0, grant_id=0, dma_ack=0, err_flag=0, busy=0, suppress=0, last_id=N_REQ-1.
REQ-033 rst asserted mid-RUN SHALL abort with channel_en=0 immediately and no dma_ack; first arbitration after release treats requester 0 as first in round-robin order.

Verification
REQ-034 Reset release, dma_req=4'b0001, mask=4'b1111 -> cfg_load 1 cycle later, channel_en next cycle, grant=4'b0001; ch_irq -> dma_ack=4'b0001 one cycle, channel_en=0.
REQ-035 dma_req=4'b1111 held, hi_prio=0, ch_irq each transfer -> grant order 0,1,2,3,0; no requester granted twice consecutively.
REQ-036 dma_req=4'b0011, hi_prio=4'b0010 -> requester 1 granted before 0 every round while both pending.
REQ-037 Requester 2 in RUN, ch_err and ch_irq same cycle -> err_flag=4'b0100, no dma_ack, requester 2 skipped until err_clr[2]=1.
REQ-038 Requester 1 acked but dma_req[1] drops one cycle later, only request -> no re-grant; busy returns 0.
REQ-039 rst low during RUN with grant=4'b0100 -> all outputs zero same cycle; after release dma_req=4'b1111 -> grant=4'b0001 first.

Source files
------------

// File: rtl/dmac_arbiter.sv
// DMA request arbiter: picks one peripheral request, sequences the single
// channel through config load, transfer and acknowledge, and keeps sticky
// per-requester bus-error flags. High-priority class wins; round-robin
// within the chosen class, starting after the last acknowledged requester.
module dmac_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         dma_req,
    input  logic [N_REQ-1:0]         req_mask,
    input  logic [N_REQ-1:0]         hi_prio,
    input  logic                     ch_irq,
    input  logic                     ch_err,
    input  logic [N_REQ-1:0]         err_clr,
    output logic                     channel_en,
    output logic                     cfg_load,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [N_REQ-1:0]         dma_ack,
    output logic [N_REQ-1:0]         err_flag,
    output logic                     busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam logic [IDW-1:0]   LAST_INIT = IDW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_ACK
    } state_t;

    state_t             r_state;
    logic               r_channel_en;
    logic               r_cfg_load;
    logic [N_REQ-1:0]   r_grant;
    logic [IDW-1:0]     r_grant_id;
    logic [N_REQ-1:0]   r_ack;
    logic [N_REQ-1:0]   r_err_flag;
    logic               r_busy;
    logic [N_REQ-1:0]   r_suppress;
    logic [IDW-1:0]     r_last_id;

    logic [N_REQ-1:0]   w_elig;
    logic [N_REQ-1:0]   w_hi;
    logic [N_REQ-1:0]   w_cand;
    logic               w_found_after;
    logic [IDW-1:0]     w_win_after;
    logic [IDW-1:0]     w_win_first;
    logic [IDW-1:0]     w_winner;
    logic [N_REQ-1:0]   w_err_set;

    assign w_elig = dma_req & req_mask & ~r_err_flag & ~r_suppress;
    assign w_hi   = w_elig & hi_prio;
    assign w_cand = (|w_hi) ? w_hi : w_elig;

    // Round-robin pick: lowest candidate above last_id, otherwise wrap to lowest candidate overall.
    always_comb begin
        w_found_after = 1'b0;
        w_win_after   = '0;
        w_win_first   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_cand[j]) begin
                w_win_first = IDW'(j);
                if (IDW'(j) > r_last_id) begin
                    w_found_after = 1'b1;
                    w_win_after   = IDW'(j);
                end
            end
        end
    end

    assign w_winner  = w_found_after ? w_win_after : w_win_first;
    assign w_err_set = (r_state == S_RUN && ch_err) ? r_grant : '0;

    // Main sequencer: state plus every registered output that depends on it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_channel_en <= 1'b0;
            r_cfg_load   <= 1'b0;
            r_grant      <= '0;
            r_grant_id   <= '0;
            r_ack        <= '0;
            r_busy       <= 1'b0;
            r_suppress   <= '0;
            r_last_id    <= LAST_INIT;
        end else begin
            r_cfg_load <= 1'b0;
            r_ack      <= '0;
            r_suppress <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|w_cand) begin
                        r_grant    <= ONE_HOT0 << w_winner;
                        r_grant_id <= w_winner;
                        r_cfg_load <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_LOAD;
                    end else begin
                        r_grant    <= '0;
                        r_grant_id <= '0;
                    end
                end
                S_LOAD: begin
                    r_channel_en <= 1'b1;
                    r_state      <= S_RUN;
                end
                S_RUN: begin
                    if (ch_err) begin
                        r_channel_en <= 1'b0;
                        r_grant      <= '0;
                        r_grant_id   <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (ch_irq) begin
                        r_channel_en <= 1'b0;
                        r_ack        <= r_grant;
                        r_state      <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_last_id  <= r_grant_id;
                    r_suppress <= r_grant;
                    r_grant    <= '0;
                    r_grant_id <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_channel_en <= 1'b0;
                    r_grant      <= '0;
                    r_grant_id   <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags: a bus error on the owner sets its bit, err_clr clears, set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_flag <= '0;
        end else begin
            r_err_flag <= (r_err_flag & ~err_clr) | w_err_set;
        end
    end

    assign channel_en = r_channel_en;
    assign cfg_load   = r_cfg_load;
    assign grant      = r_grant;
    assign grant_id   = r_grant_id;
    assign dma_ack    = r_ack;
    assign err_flag   = r_err_flag;
    assign busy       = r_busy;

endmodule

// File: tb/tb_dmac_arbiter.sv
// Bench for dmac_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_dmac_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] dma_req;
    logic [3:0] req_mask;
    logic [3:0] hi_prio;
    logic       ch_irq;
    logic       ch_err;
    logic [3:0] err_clr;
    logic       channel_en;
    logic       cfg_load;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic [3:0] dma_ack;
    logic [3:0] err_flag;
    logic       busy;

    int nAsserts = 0;
    int nFail    = 0;

    // Model: phase 0 idle, 1 config load, 2 transfer running, 3 acknowledge
    int mPhase;
    int mOwner;
    int mLast;
    int mErr;
    int mSupp;

    int got[$];

    dmac_arbiter #(.N_REQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .dma_req    (dma_req),
        .req_mask   (req_mask),
        .hi_prio    (hi_prio),
        .ch_irq     (ch_irq),
        .ch_err     (ch_err),
        .err_clr    (err_clr),
        .channel_en (channel_en),
        .cfg_load   (cfg_load),
        .grant      (grant),
        .grant_id   (grant_id),
        .dma_ack    (dma_ack),
        .err_flag   (err_flag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPhase = 0;
        mOwner = 0;
        mLast  = 3;
        mErr   = 0;
        mSupp  = -1;
    endtask

    // Advance the model by one clock using the inputs as sampled at the edge.
    task automatic modelEdge();
        int elig;
        int hiSet;
        int pick;
        int idx;
        int suppMask;
        int newErr;
        bit found;
        newErr = (mErr & ~int'(err_clr)) | ((mPhase == 2 && ch_err) ? (1 << mOwner) : 0);
        suppMask = (mSupp >= 0) ? (1 << mSupp) : 0;
        mSupp = -1;
        case (mPhase)
            0: begin
                elig  = int'(dma_req) & int'(req_mask) & ~mErr & ~suppMask & 15;
                hiSet = elig & int'(hi_prio);
                pick  = (hiSet != 0) ? hiSet : elig;
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    idx = (mLast + k) % 4;
                    if (!found && ((pick >> idx) & 1) == 1) begin
                        found  = 1'b1;
                        mOwner = idx;
                    end
                end
                if (found) mPhase = 1;
            end
            1: mPhase = 2;
            2: begin
                if (ch_err) mPhase = 0;
                else if (ch_irq) mPhase = 3;
            end
            default: begin
                mLast  = mOwner;
                mSupp  = mOwner;
                mPhase = 0;
            end
        endcase
        mErr = newErr;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".grant"},      grant,      (mPhase != 0) ? (1 << mOwner) : 0);
        chk({tag, ".grant_id"},   grant_id,   (mPhase != 0) ? mOwner : 0);
        chk({tag, ".cfg_load"},   cfg_load,   (mPhase == 1) ? 1 : 0);
        chk({tag, ".channel_en"}, channel_en, (mPhase == 2) ? 1 : 0);
        chk({tag, ".dma_ack"},    dma_ack,    (mPhase == 3) ? (1 << mOwner) : 0);
        chk({tag, ".err_flag"},   err_flag,   mErr);
        chk({tag, ".busy"},       busy,       (mPhase != 0) ? 1 : 0);
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] mask,
                                 input logic [3:0] hi, input logic irq,
                                 input logic err, input logic [3:0] clr);
        dma_req  = req;
        req_mask = mask;
        hi_prio  = hi;
        ch_irq   = irq;
        ch_err   = err;
        err_clr  = clr;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    task automatic doReset();
        applyStimulus(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
        rst = 1'b0;
        modelReset();
        #2;
        checkOutput("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
        #12;

        // Single request, full handshake
        doReset();
        applyStimulus(4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("single_load");
        chk("single_cfg_load", cfg_load, 1);
        chk("single_grant", grant, 4'b0001);
        step("single_run");
        chk("single_chen", channel_en, 1);
        applyStimulus(4'b0001, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000);
        step("single_ack");
        chk("single_ack", dma_ack, 4'b0001);
        chk("single_chen_off", channel_en, 0);
        applyStimulus(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("single_idle");
        chk("single_ack_gone", dma_ack, 0);

        // Round-robin among four equal requesters
        doReset();
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000);
        got.delete();
        for (int c = 0; c < 20; c++) begin
            step("rr");
            if (cfg_load) got.push_back(int'(grant_id));
        end
        chk("rr_count", got.size(), 5);
        if (got.size() == 5) begin
            chk("rr_g0", got[0], 0);
            chk("rr_g1", got[1], 1);
            chk("rr_g2", got[2], 2);
            chk("rr_g3", got[3], 3);
            chk("rr_g4", got[4], 0);
        end

        // High-priority class goes first each round
        doReset();
        applyStimulus(4'b0011, 4'b1111, 4'b0010, 1'b1, 1'b0, 4'b0000);
        got.delete();
        for (int c = 0; c < 16; c++) begin
            step("hp");
            if (cfg_load) got.push_back(int'(grant_id));
        end
        chk("hp_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("hp_g0", got[0], 1);
            chk("hp_g1", got[1], 0);
            chk("hp_g2", got[2], 1);
            chk("hp_g3", got[3], 0);
        end

        // Bus error with simultaneous irq: sticky flag, no ack, requester skipped until cleared
        doReset();
        applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("err_load");
        step("err_run");
        applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000);
        step("err_hit");
        chk("err_flag_set", err_flag, 4'b0100);
        chk("err_no_ack", dma_ack, 0);
        chk("err_chen_off", channel_en, 0);
        applyStimulus(4'b0101, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("err_skip");
        chk("err_skip_id", grant_id, 0);
        applyStimulus(4'b0101, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000);
        step("err_run0");
        step("err_ack0");
        applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("err_idle0");
        step("err_idle1");
        chk("err_blocked", busy, 0);
        applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100);
        step("err_clr");
        chk("err_cleared", err_flag, 0);
        applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("err_regrant");
        chk("err_regrant_id", grant_id, 2);

        // Request dropped right after acknowledge is not granted again
        doReset();
        applyStimulus(4'b0010, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000);
        step("drop_load");
        step("drop_run");
        step("drop_ack");
        chk("drop_ack", dma_ack, 4'b0010);
        step("drop_supp");
        chk("drop_supp_busy", busy, 0);
        applyStimulus(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("drop_gone");
        chk("drop_busy", busy, 0);
        chk("drop_grant", grant, 0);

        // Asynchronous reset in the middle of a transfer
        doReset();
        applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("ar_load");
        step("ar_run");
        chk("ar_grant_before", grant, 4'b0100);
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        chk("ar_chen", channel_en, 0);
        chk("ar_grant", grant, 0);
        chk("ar_busy", busy, 0);
        checkOutput("ar_async");
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("ar_first");
        chk("ar_first_grant", grant, 4'b0001);

        // Random traffic against the model
        doReset();
        for (int c = 0; c < 600; c++) begin
            applyStimulus(4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111,
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
